axi4_lite_cmd_master: RTL and testbench

AXI4_LITE_CMD_MASTER -- requirements
Module: axi4_lite_cmd_master

---
 rtl/axi4_lite_cmd_master_if.sv | 43 ++++
 rtl/axi4_lite_cmd_master.sv | 181 ++++++++++++++++++
 tb/tb_axi4_lite_cmd_master.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_cmd_master_if.sv
// AXI4-Lite bus bundle shared by the command master and its register slave.
// Every channel transfers on a rising clk edge where its valid and ready are both high;
// a source holds valid and payload stable until that edge and never waits for ready first.
interface ifc_axi4_lite #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding command to AXI4-Lite master: one read or write per command,
// one response per command, optional bus-wait timeout for debug recovery.
module axi4_lite_cmd_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  ifc_axi4_lite.master                if_axi,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                  o_rsp_resp,
  output logic                        o_rsp_timeout,
  output logic                        o_busy,
  output logic [2:0]                  dbg_state
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RSP          = 3'd5
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic          in_bus, leave, timeout_hit, abort;
  logic [CW-1:0] cnt_inc;

  assign aw_hs = if_axi.awvalid && if_axi.awready;
  assign w_hs  = if_axi.wvalid  && if_axi.wready;
  assign b_hs  = if_axi.bvalid  && if_axi.bready;
  assign ar_hs = if_axi.arvalid && if_axi.arready;
  assign r_hs  = if_axi.rvalid  && if_axi.rready;

  assign in_bus = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                  (state == RD_ADDR) || (state == RD_DATA);

  // A channel whose valid is already low has completed its handshake.
  always_comb begin
    leave = 1'b0;
    case (state)
      WR_ADDR_DATA: leave = (!if_axi.awvalid || aw_hs) && (!if_axi.wvalid || w_hs);
      WR_RESP:      leave = b_hs;
      RD_ADDR:      leave = ar_hs;
      RD_DATA:      leave = r_hs;
      default:      leave = 1'b0;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
  assign abort       = in_bus && timeout_hit && !leave;
  assign cnt_inc     = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

  assign o_busy    = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      o_cmd_ready    <= 1'b1;
      o_rsp_valid    <= 1'b0;
      o_rsp_rdata    <= '0;
      o_rsp_resp     <= 2'b00;
      o_rsp_timeout  <= 1'b0;
      if_axi.awaddr  <= '0;
      if_axi.awprot  <= 3'b000;
      if_axi.awvalid <= 1'b0;
      if_axi.wdata   <= '0;
      if_axi.wstrb   <= '0;
      if_axi.wvalid  <= 1'b0;
      if_axi.bready  <= 1'b0;
      if_axi.araddr  <= '0;
      if_axi.arprot  <= 3'b000;
      if_axi.arvalid <= 1'b0;
      if_axi.rready  <= 1'b0;
    end else if (abort) begin
      // Slave is assumed wedged; it needs a reset before the next command.
      if_axi.awvalid <= 1'b0;
      if_axi.wvalid  <= 1'b0;
      if_axi.arvalid <= 1'b0;
      if_axi.bready  <= 1'b0;
      if_axi.rready  <= 1'b0;
      o_rsp_resp     <= 2'b10;
      o_rsp_timeout  <= 1'b1;
      o_rsp_rdata    <= '0;
      o_rsp_valid    <= 1'b1;
      state          <= RSP;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            o_cmd_ready <= 1'b0;
            cnt         <= '0;
            if (i_cmd_write) begin
              if_axi.awaddr  <= i_cmd_addr;
              if_axi.wdata   <= i_cmd_wdata;
              if_axi.wstrb   <= i_cmd_wstrb;
              if_axi.awvalid <= 1'b1;
              if_axi.wvalid  <= 1'b1;
              state          <= WR_ADDR_DATA;
            end else begin
              if_axi.araddr  <= i_cmd_addr;
              if_axi.arvalid <= 1'b1;
              state          <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (aw_hs) if_axi.awvalid <= 1'b0;
          if (w_hs)  if_axi.wvalid  <= 1'b0;
          if (leave) begin
            if_axi.bready <= 1'b1;
            cnt           <= '0;
            state         <= WR_RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            if_axi.bready <= 1'b0;
            o_rsp_resp    <= if_axi.bresp;
            o_rsp_rdata   <= '0;
            o_rsp_timeout <= 1'b0;
            o_rsp_valid   <= 1'b1;
            state         <= RSP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            if_axi.arvalid <= 1'b0;
            if_axi.rready  <= 1'b1;
            cnt            <= '0;
            state          <= RD_DATA;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            if_axi.rready <= 1'b0;
            o_rsp_resp    <= if_axi.rresp;
            o_rsp_rdata   <= if_axi.rdata;
            o_rsp_timeout <= 1'b0;
            o_rsp_valid   <= 1'b1;
            state         <= RSP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Directed bench for axi4_lite_cmd_master: scoreboard on the response port plus
// per-cycle history of bus signals for latency and handshake-shape checks.
module tb_axi4_lite_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int HN = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout, busy;
  logic [2:0]    dbg_state;

  ifc_axi4_lite #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  axi4_lite_cmd_master #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .if_axi(axi),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_resp(rsp_resp), .o_rsp_timeout(rsp_timeout), .o_busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [34:0] exp_q[$];  // {timeout, resp, rdata}

  function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // slave configuration (ready delay in cycles of valid, -1 = never)
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic        b_en = 1'b1;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;

  initial begin
    int aw_wait, w_wait, ar_wait;
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (axi.awvalid) begin axi.awready = (aw_dly >= 0) && (aw_wait >= aw_dly); aw_wait++; end
      else begin axi.awready = 1'b0; aw_wait = 0; end
      if (axi.wvalid) begin axi.wready = (w_dly >= 0) && (w_wait >= w_dly); w_wait++; end
      else begin axi.wready = 1'b0; w_wait = 0; end
      if (axi.arvalid) begin axi.arready = (ar_dly >= 0) && (ar_wait >= ar_dly); ar_wait++; end
      else begin axi.arready = 1'b0; ar_wait = 0; end
      axi.bvalid = axi.bready && b_en;
      axi.bresp  = b_resp_cfg;
      axi.rvalid = axi.rready;
      axi.rdata  = r_data_cfg;
      axi.rresp  = r_resp_cfg;
    end
  end

  // per-cycle history, sampled mid-cycle
  int          cyc = 0, acc_cyc = -1, hs_cyc = -1;
  logic        h_aw[HN], h_w[HN], h_ar[HN], h_b[HN], h_r[HN], h_rv[HN];
  logic [31:0] h_awaddr[HN], h_wdata[HN];

  initial begin
    forever begin
      @(negedge clk);
      h_aw[cyc] = axi.awvalid; h_w[cyc] = axi.wvalid; h_ar[cyc] = axi.arvalid;
      h_b[cyc] = axi.bready; h_r[cyc] = axi.rready; h_rv[cyc] = rsp_valid;
      h_awaddr[cyc] = axi.awaddr; h_wdata[cyc] = axi.wdata;
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (rsp_valid && rsp_ready) hs_cyc = cyc;
      if (cyc < HN - 1) cyc++;
    end
  end

  // scoreboard monitor
  int          n_rsp = 0;
  logic        prev_hold = 1'b0;
  logic [34:0] prev_rsp;

  initial begin
    logic [34:0] cur;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        cur = {rsp_timeout, rsp_resp, rsp_rdata};
        if (prev_hold) check("rsp_stable", cur, prev_rsp);
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_unexpected: got 0x%0h expected none", cur);
          end else begin
            check("rsp", cur, exp_q.pop_front());
          end
          n_rsp++;
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_rsp  = cur;
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cmd_accept", ok, 1'b1);
  endtask

  task automatic wait_rsp(input int target);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_rsp >= target) begin ok = 1'b1; break; end
    end
    check("rsp_arrival", ok, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected end of test");
    $fatal(1);
  end

  initial begin
    int n, m, cnt_ar;
    logic ok, busy_ok;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    check("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, '0);
    check("rst_axi_vr", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);

    // write, always-ready slave
    exp_q.push_back({1'b0, 2'b00, 32'h0});
    send(1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
    n = acc_cyc;
    wait_rsp(1);
    check("wr_aw_w_n1", {h_aw[n+1], h_w[n+1]}, 2'b11);
    check("wr_awaddr", h_awaddr[n+1], 32'h04);
    check("wr_wdata", h_wdata[n+1], 32'hDEADBEEF);
    check("wr_prot", {axi.awprot, axi.arprot}, 6'b0);
    check("wr_aw_drop", {h_aw[n+2], h_w[n+2]}, 2'b00);
    check("wr_bready_n2", h_b[n+2], 1'b1);
    check("wr_rsp_lat", {h_rv[n+2], h_rv[n+3]}, 2'b01);

    // read, arready after 3 cycles
    ar_dly = 3; r_data_cfg = 32'h12345678; r_resp_cfg = 2'b00;
    exp_q.push_back({1'b0, 2'b00, 32'h12345678});
    send(1'b0, 32'h08, 32'h0, 4'h0);
    n = acc_cyc;
    wait_rsp(2);
    cnt_ar = 0;
    for (int i = 1; i <= 7; i++) if (h_ar[n+i]) cnt_ar++;
    check("rd_arvalid_len", cnt_ar, 4);
    check("rd_arvalid_last", {h_ar[n+4], h_ar[n+5]}, 2'b10);
    check("rd_rready", {h_r[n+4], h_r[n+5]}, 2'b01);
    check("rd_rsp_lat", {h_rv[n+5], h_rv[n+6]}, 2'b01);

    // write, awready immediate, wready after 3 cycles
    ar_dly = 0; w_dly = 3; b_resp_cfg = 2'b10;
    exp_q.push_back({1'b0, 2'b10, 32'h0});
    send(1'b1, 32'h0C, 32'hCAFEF00D, 4'hF);
    n = acc_cyc;
    wait_rsp(3);
    repeat (3) @(negedge clk);
    check("split_aw", {h_aw[n+1], h_aw[n+2]}, 2'b10);
    check("split_w", {h_w[n+4], h_w[n+5]}, 2'b10);
    check("split_bready", {h_b[n+4], h_b[n+5]}, 2'b01);
    check("split_single_rsp", n_rsp, 3);
    w_dly = 0; b_resp_cfg = 2'b00;

    // read timeout
    ar_dly = -1;
    exp_q.push_back({1'b1, 2'b10, 32'h0});
    send(1'b0, 32'h40, 32'h0, 4'h0);
    n = acc_cyc;
    wait_rsp(4);
    check("to_arvalid", {h_ar[n+1], h_ar[n+8], h_ar[n+9]}, 3'b110);
    check("to_rsp_lat", {h_rv[n+8], h_rv[n+9]}, 2'b01);
    ar_dly = 0;

    // response back-pressure, command presented while busy
    r_data_cfg = 32'hA5A50F0F;
    exp_q.push_back({1'b0, 2'b00, 32'hA5A50F0F});
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(1'b0, 32'h30, 32'h0, 4'h0);
    n = acc_cyc;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hFC;
    busy_ok = 1'b1; m = 0; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) m++;
      if (cmd_ready) busy_ok = 1'b0;
      if (m == 5) begin ok = 1'b1; break; end
    end
    check("bp_held5", ok, 1'b1);
    check("bp_no_accept", busy_ok, 1'b1);
    check("bp_rsp_lat", {h_rv[n+2], h_rv[n+3]}, 2'b01);
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 2'b00, 32'h0});
    cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'h3;
    rsp_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp_accept_found", ok, 1'b1);
    check("bp_accept_cycle", acc_cyc, hs_cyc + 1);
    n = acc_cyc;
    wait_rsp(6);
    check("bp_wr_addr", h_awaddr[n+1], 32'h10);
    check("bp_wr_data", h_wdata[n+1], 32'h0BADF00D);

    // reset while waiting on the write response
    b_en = 1'b0;
    send(1'b1, 32'h20, 32'h55, 4'hF);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.bready) begin ok = 1'b1; break; end
    end
    check("mid_rst_in_wr_resp", ok, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_axi_vr", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
    check("mid_rst_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b0);
    check("mid_rst_busy", busy, 1'b0);
    #2 rst = 1'b0;
    b_en = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {cmd_ready, busy}, 2'b10);
    exp_q.push_back({1'b0, 2'b00, 32'h0});
    send(1'b1, 32'h24, 32'h11223344, 4'hF);
    n = acc_cyc;
    wait_rsp(7);
    check("post_rst_wr", {h_awaddr[n+1], h_wdata[n+1]}, {32'h24, 32'h11223344});
    check("post_rst_lat", {h_rv[n+2], h_rv[n+3]}, 2'b01);

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
